keypad_bcd_entry: RTL and testbench

//   Parametrised successor to the one-hot keypad encoder: turns a 16-bit one-hot keypad scan into decimal digits
//   and shifts them into a DIGITS-wide BCD entry register, calculator style (new digit enters at LSD).

---
 rtl/keypad_bcd_entry.sv | 181 ++++++++++++++++++
 tb/tb_keypad_bcd_entry.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_bcd_entry.sv
// Debounced one-hot keypad to calculator-style BCD entry register with CLEAR/ENTER keys.
// Optional macro KEYPAD_BACKSPACE_EN turns keypad bit1 into a BACKSPACE key.
module keypad_bcd_entry #(
    parameter int DIGITS          = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           onehot,
    output logic [4*DIGITS-1:0]   binary,
    output logic [7:0]            times,
    output logic                  full,
    output logic                  key_valid,
    output logic                  overflow,
    output logic                  done,
    output logic [4*DIGITS-1:0]   value
);

    typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_HELD} state_t;
    typedef enum logic [2:0] {K_DIGIT, K_CLEAR, K_ENTER, K_BKSP, K_INVALID} key_kind_t;

    localparam logic [7:0] DB_LIMIT   = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] DIGITS_LIM = 8'(DIGITS);

    state_t               r_state, w_state_next;
    logic [15:0]          r_sample, r_code, w_code_next;
    logic [7:0]           r_cnt, w_cnt_next;
    logic                 w_act;
    key_kind_t            w_kind;
    logic [3:0]           w_digit;
    logic [4*DIGITS-1:0]  r_binary, r_value, w_shifted;
    logic [7:0]           r_times;
    logic                 r_key_valid, r_overflow, r_done;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_kind  = K_INVALID;
        w_digit = 4'd0;
        case (r_sample)
            16'h0008: begin w_kind = K_DIGIT; w_digit = 4'd0; end
            16'h0080: begin w_kind = K_DIGIT; w_digit = 4'd1; end
            16'h0040: begin w_kind = K_DIGIT; w_digit = 4'd2; end
            16'h0020: begin w_kind = K_DIGIT; w_digit = 4'd3; end
            16'h0800: begin w_kind = K_DIGIT; w_digit = 4'd4; end
            16'h0400: begin w_kind = K_DIGIT; w_digit = 4'd5; end
            16'h0200: begin w_kind = K_DIGIT; w_digit = 4'd6; end
            16'h8000: begin w_kind = K_DIGIT; w_digit = 4'd7; end
            16'h4000: begin w_kind = K_DIGIT; w_digit = 4'd8; end
            16'h2000: begin w_kind = K_DIGIT; w_digit = 4'd9; end
            16'h0001: w_kind = K_CLEAR;
            16'h0010: w_kind = K_ENTER;
`ifdef KEYPAD_BACKSPACE_EN
            16'h0002: w_kind = K_BKSP;
`endif
            default:  w_kind = K_INVALID;
        endcase
    end

    generate
        if (DIGITS == 1) begin : g_load
            assign w_shifted = w_digit;
        end else begin : g_shift
            assign w_shifted = {r_binary[4*DIGITS-5:0], w_digit};
        end
    endgenerate

    // The key is acted on in the same decision that completes the debounce count.
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        w_cnt_next   = r_cnt;
        w_act        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sample != 16'h0000) begin
                    w_code_next = r_sample;
                    w_cnt_next  = 8'd1;
                    if (w_cnt_next >= DB_LIMIT) begin
                        w_act        = 1'b1;
                        w_state_next = ST_HELD;
                    end else begin
                        w_state_next = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (r_sample == r_code) begin
                    w_cnt_next = r_cnt + 8'd1;
                    if (w_cnt_next >= DB_LIMIT) begin
                        w_act        = 1'b1;
                        w_state_next = ST_HELD;
                    end
                end else begin
                    w_cnt_next   = 8'd0;
                    w_state_next = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (r_sample == 16'h0000) begin
                    w_cnt_next   = 8'd0;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_cnt_next   = 8'd0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= 16'h0000;
            r_state  <= ST_IDLE;
            r_code   <= 16'h0000;
            r_cnt    <= 8'd0;
        end else begin
            r_sample <= onehot;
            r_state  <= w_state_next;
            r_code   <= w_code_next;
            r_cnt    <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_binary    <= '0;
            r_value     <= '0;
            r_times     <= 8'd0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            if (w_act) begin
                case (w_kind)
                    K_DIGIT: begin
                        if (r_times < DIGITS_LIM) begin
                            r_binary    <= w_shifted;
                            r_times     <= r_times + 8'd1;
                            r_key_valid <= 1'b1;
                        end else begin
                            r_overflow  <= 1'b1;
                        end
                    end
                    K_CLEAR: begin
                        r_binary <= '0;
                        r_times  <= 8'd0;
                    end
                    K_ENTER: begin
                        r_value  <= r_binary;
                        r_binary <= '0;
                        r_times  <= 8'd0;
                        r_done   <= 1'b1;
                    end
`ifdef KEYPAD_BACKSPACE_EN
                    K_BKSP: begin
                        if (r_times != 8'd0) begin
                            r_binary <= r_binary >> 4;
                            r_times  <= r_times - 8'd1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign binary    = r_binary;
    assign times     = r_times;
    assign full      = (r_times == DIGITS_LIM);
    assign key_valid = r_key_valid;
    assign overflow  = r_overflow;
    assign done      = r_done;
    assign value     = r_value;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed table-driven bench for keypad_bcd_entry (DIGITS=3, DEBOUNCE_CYCLES=4),
// plus hand sequences for latency, bounce, backspace and reset during a press.
module tb_keypad_bcd_entry;

    logic        clk;
    logic        rst_n;
    logic [15:0] onehot;
    logic [11:0] binary;
    logic [7:0]  times;
    logic        full;
    logic        key_valid;
    logic        overflow;
    logic        done;
    logic [11:0] value;

    int n_cmp  = 0;
    int n_fail = 0;
    int kv_cnt = 0;
    int ov_cnt = 0;
    int dn_cnt = 0;

    keypad_bcd_entry #(.DIGITS(3), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .onehot    (onehot),
        .binary    (binary),
        .times     (times),
        .full      (full),
        .key_valid (key_valid),
        .overflow  (overflow),
        .done      (done),
        .value     (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (overflow)  ov_cnt++;
        if (done)      dn_cnt++;
    end

    typedef struct {
        logic [15:0] code;
        int          hold;
        logic [11:0] bin;
        logic [7:0]  t;
        logic        f;
        int          kv;
        int          ov;
        int          dn;
        logic [11:0] val;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        kv_cnt = 0;
        ov_cnt = 0;
        dn_cnt = 0;
    endtask

    task automatic press(input logic [15:0] code, input int hold);
        clear_counts();
        onehot = code;
        repeat (hold) @(negedge clk);
        onehot = 16'h0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [11:0] b, input logic [7:0] t,
                               input int kv, input int ov, input int dn);
        check({tag, " binary"},    32'(binary), 32'(b));
        check({tag, " times"},     32'(times),  32'(t));
        check({tag, " key_valid"}, 32'(kv_cnt), 32'(kv));
        check({tag, " overflow"},  32'(ov_cnt), 32'(ov));
        check({tag, " done"},      32'(dn_cnt), 32'(dn));
    endtask

    initial begin
        vecs[0]  = '{16'h0001,  5, 12'h000, 8'd0, 1'b0, 0, 0, 0, 12'h000};
        vecs[1]  = '{16'h0080,  6, 12'h001, 8'd1, 1'b0, 1, 0, 0, 12'h000};
        vecs[2]  = '{16'h0040,  5, 12'h012, 8'd2, 1'b0, 1, 0, 0, 12'h000};
        vecs[3]  = '{16'h0020,  5, 12'h123, 8'd3, 1'b1, 1, 0, 0, 12'h000};
        vecs[4]  = '{16'h0800,  5, 12'h123, 8'd3, 1'b1, 0, 1, 0, 12'h000};
        vecs[5]  = '{16'h0010, 20, 12'h000, 8'd0, 1'b0, 0, 0, 1, 12'h123};
        vecs[6]  = '{16'h2000,  5, 12'h009, 8'd1, 1'b0, 1, 0, 0, 12'h123};
        vecs[7]  = '{16'h4000,  5, 12'h098, 8'd2, 1'b0, 1, 0, 0, 12'h123};
        vecs[8]  = '{16'h0010, 20, 12'h000, 8'd0, 1'b0, 0, 0, 1, 12'h098};
        vecs[9]  = '{16'h0088, 10, 12'h000, 8'd0, 1'b0, 0, 0, 0, 12'h098};
        vecs[10] = '{16'h0800,  5, 12'h004, 8'd1, 1'b0, 1, 0, 0, 12'h098};
        vecs[11] = '{16'h0400,  5, 12'h045, 8'd2, 1'b0, 1, 0, 0, 12'h098};
        vecs[12] = '{16'h0001,  5, 12'h000, 8'd0, 1'b0, 0, 0, 0, 12'h098};
        vecs[13] = '{16'h0004,  6, 12'h000, 8'd0, 1'b0, 0, 0, 0, 12'h098};
        vecs[14] = '{16'h0002,  6, 12'h000, 8'd0, 1'b0, 0, 0, 0, 12'h098};
        vecs[15] = '{16'h0010,  5, 12'h000, 8'd0, 1'b0, 0, 0, 1, 12'h000};
        vecs[16] = '{16'h0008,  5, 12'h000, 8'd1, 1'b0, 1, 0, 0, 12'h000};
        vecs[17] = '{16'h8000,  5, 12'h007, 8'd2, 1'b0, 1, 0, 0, 12'h000};
        vecs[18] = '{16'h0200,  5, 12'h076, 8'd3, 1'b1, 1, 0, 0, 12'h000};
        vecs[19] = '{16'h0010,  5, 12'h000, 8'd0, 1'b0, 0, 0, 1, 12'h076};
        vecs[20] = '{16'h0080,  5, 12'h001, 8'd1, 1'b0, 1, 0, 0, 12'h076};

        rst_n  = 1'b0;
        onehot = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset binary",    32'(binary),    32'h0);
        check("reset times",     32'(times),     32'h0);
        check("reset full",      32'(full),      32'h0);
        check("reset key_valid", 32'(key_valid), 32'h0);
        check("reset overflow",  32'(overflow),  32'h0);
        check("reset done",      32'(done),      32'h0);
        check("reset value",     32'(value),     32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Latency: pulse appears after the 5th rising edge following the press.
        clear_counts();
        onehot = 16'h0080;
        repeat (4) @(negedge clk);
        check("latency early kv", 32'(key_valid), 32'h0);
        @(negedge clk);
        check("latency kv", 32'(key_valid), 32'h1);
        @(negedge clk);
        check("latency kv width", 32'(key_valid), 32'h0);
        onehot = 16'h0000;
        repeat (4) @(negedge clk);
        check_state("first press", 12'h001, 8'd1, 1, 0, 0);

        for (int i = 0; i < 21; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            press(vecs[i].code, vecs[i].hold);
            check_state(tag, vecs[i].bin, vecs[i].t, vecs[i].kv, vecs[i].ov, vecs[i].dn);
            check({tag, " full"},  32'(full),  32'(vecs[i].f));
            check({tag, " value"}, 32'(value), 32'(vecs[i].val));
        end

        // Bounce: 2 high, 1 low, 2 high never reaches four matching samples.
        clear_counts();
        onehot = 16'h0040; repeat (2) @(negedge clk);
        onehot = 16'h0000; @(negedge clk);
        onehot = 16'h0040; repeat (2) @(negedge clk);
        onehot = 16'h0000; repeat (6) @(negedge clk);
        check_state("bounce", 12'h001, 8'd1, 0, 0, 0);

`ifdef KEYPAD_BACKSPACE_EN
        press(16'h0001, 5);
        press(16'h0800, 5);
        press(16'h0400, 5);
        press(16'h0200, 5);
        check_state("bksp pre", 12'h456, 8'd3, 1, 0, 0);
        press(16'h0002, 5);
        check_state("bksp 1", 12'h045, 8'd2, 0, 0, 0);
        press(16'h0002, 5);
        press(16'h0002, 5);
        check_state("bksp 3", 12'h000, 8'd0, 0, 0, 0);
        press(16'h0002, 5);
        check_state("bksp empty", 12'h000, 8'd0, 0, 0, 0);
        press(16'h0080, 5);
        check_state("bksp after", 12'h001, 8'd1, 1, 0, 0);
`endif

        // Reset in the middle of a debounce; the still-held key is a new press afterwards.
        clear_counts();
        onehot = 16'h0040;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst binary", 32'(binary), 32'h0);
        check("midrst times",  32'(times),  32'h0);
        check("midrst value",  32'(value),  32'h0);
        check("midrst full",   32'(full),   32'h0);
        repeat (3) @(negedge clk);
        check("midrst kv held", 32'(key_valid), 32'h0);
        rst_n = 1'b1;
        clear_counts();
        repeat (6) @(negedge clk);
        onehot = 16'h0000;
        repeat (4) @(negedge clk);
        check_state("after rst", 12'h002, 8'd1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
